// File: rtl/ssp_byte_rx.sv
// ssp_byte_rx: SSP serial byte receiver with input synchronizers and a FWFT byte FIFO
//   pck0       - main clock, all logic on rising edge
//   rst        - asynchronous active-high reset
//   ssp_clk    - SSP bit clock (asynchronous), bits captured on its rising edge
//   ssp_frame  - high while the bits of a byte are shifted
//   ssp_dout   - serial data, MSB first
//   rd_en      - pop the head byte
//   clr        - clear sticky error flags
//   data_out   - head byte (8'h00 when empty)
//   data_valid - FIFO not empty
//   fifo_level - FIFO occupancy
//   overflow   - sticky: completed byte dropped because FIFO full
//   frame_err  - sticky: frame ended mid-byte
module ssp_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       pck0,
    input  logic       rst,
    input  logic       ssp_clk,
    input  logic       ssp_frame,
    input  logic       ssp_dout,
    input  logic       rd_en,
    input  logic       clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [4:0] fifo_level,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] clk_sr, frame_sr, dout_sr;
    logic                   clk_prev;
    state_t                 state;
    logic [2:0]             cnt;
    // The eighth bit is taken straight from the synchronizer, so only the
    // seven earlier bits need holding.
    logic [6:0]             shreg;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wp, rp;
    logic                   clk_s, frame_s, dout_s, bit_ev, push, pop, full, wr;
    logic                   set_ovf, set_ferr;

    always_comb begin
        clk_s      = clk_sr[SYNC_STAGES-1];
        frame_s    = frame_sr[SYNC_STAGES-1];
        dout_s     = dout_sr[SYNC_STAGES-1];
        bit_ev     = clk_s & ~clk_prev;
        push       = bit_ev & frame_s & (state == SHIFT) & (cnt == 3'd7);
        data_valid = fifo_level != 5'd0;
        full       = fifo_level == 5'(FIFO_DEPTH);
        pop        = rd_en & data_valid;
        wr         = push & (~full | pop);
        set_ovf    = push & full & ~pop;
        set_ferr   = (state == SHIFT) & ~frame_s & (cnt != 3'd0);
        data_out   = data_valid ? mem[rp] : 8'h00;
    end

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            clk_sr     <= '0;
            frame_sr   <= '0;
            dout_sr    <= '0;
            clk_prev   <= 1'b0;
            state      <= IDLE;
            cnt        <= 3'd0;
            shreg      <= 7'd0;
            wp         <= '0;
            rp         <= '0;
            fifo_level <= 5'd0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sr     <= {clk_sr[SYNC_STAGES-2:0], ssp_clk};
            frame_sr   <= {frame_sr[SYNC_STAGES-2:0], ssp_frame};
            dout_sr    <= {dout_sr[SYNC_STAGES-2:0], ssp_dout};
            clk_prev   <= clk_s;
            if (state == IDLE) begin
                if (bit_ev && frame_s) begin
                    state <= SHIFT;
                    cnt   <= 3'd1;
                    shreg <= {shreg[5:0], dout_s};
                end
            end else if (!frame_s) begin
                state <= IDLE;
                cnt   <= 3'd0;
            end else if (bit_ev) begin
                cnt   <= cnt + 3'd1;
                shreg <= {shreg[5:0], dout_s};
            end
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            fifo_level <= fifo_level + {4'd0, wr} - {4'd0, pop};
            overflow   <= set_ovf | (overflow & ~clr);
            frame_err  <= set_ferr | (frame_err & ~clr);
        end
    end

    always_ff @(posedge pck0) begin
        if (wr)
            mem[wp] <= {shreg, dout_s};
    end
endmodule
